// File: rtl/synth_pkg.sv
// Shared definitions for the voice envelope: state encoding, full-scale level
// and the rate-to-step shifts.
package synth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } env_state_t;

  localparam logic [15:0] LEVEL_MAX = 16'hFFFF;
  localparam int          ATK_SHIFT = 8;
  localparam int          DR_SHIFT  = 4;

  // (rate+1) << shift, 17 bits wide so an attack rate of 0xFF yields 0x10000.
  function automatic logic [16:0] rate_step(input logic [7:0] rate, input int shift);
    logic [16:0] base;
    base = {9'd0, rate} + 17'd1;
    return base << shift;
  endfunction

endpackage

// File: rtl/env_step_sat.sv
// One envelope step: add or subtract with a (W+1)-bit intermediate, clamping to
// the bound and flagging when the bound was reached.
module env_step_sat #(
  parameter int W = 16
) (
  input  logic [W-1:0] level,
  input  logic [W:0]   step,
  input  logic [W-1:0] bound,
  input  logic         sub,
  output logic [W-1:0] result,
  output logic         reached
);

  logic [W:0] sum;
  logic [W:0] diff;
  logic       under;

  // NOTE: every output of a combinational block is assigned on every path, so
  // no latch can be inferred.
  always_comb begin
    sum   = {1'b0, level} + step;
    diff  = {1'b0, level} - step;
    under = step > {1'b0, level};
    if (sub) begin
      reached = under || (diff[W-1:0] <= bound);
      result  = reached ? bound : diff[W-1:0];
    end else begin
      reached = sum > {1'b0, bound};
      result  = reached ? bound : sum[W-1:0];
    end
  end

endmodule

// File: rtl/envelope_adsr.sv
// Per-voice ADSR envelope: gate-driven five-state machine advancing on the audio
// tick, and a registered sample-by-level multiplier.
module envelope_adsr
  import synth_pkg::*;
#(
  parameter int LEVEL_W  = 16,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       gate,
  input  logic                       sample_tick,
  input  logic [7:0]                 attack_rate,
  input  logic [7:0]                 decay_rate,
  input  logic [7:0]                 sustain_level,
  input  logic [7:0]                 release_rate,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic [LEVEL_W-1:0]         env_level,
  output logic                       active
);

  env_state_t                         state;
  logic [LEVEL_W-1:0]                 level;
  logic                               gate_q;
  logic                               trig_pending;
  logic                               trig;
  logic [LEVEL_W:0]                   step;
  logic [LEVEL_W-1:0]                 bound;
  logic                               sub;
  logic [LEVEL_W-1:0]                 step_result;
  logic                               reached;
  logic [LEVEL_W-1:0]                 target;
  logic signed [SAMPLE_W+LEVEL_W:0]   product;

  assign target    = {sustain_level, 8'h00};
  assign trig      = trig_pending | (gate & ~gate_q);
  assign env_level = level;
  assign active    = (state != ST_IDLE);
  assign product   = sample_in * $signed({1'b0, level});

  always_comb begin
    step  = '0;
    bound = '0;
    sub   = 1'b1;
    case (state)
      ST_ATTACK: begin
        step  = rate_step(attack_rate, ATK_SHIFT);
        bound = LEVEL_MAX;
        sub   = 1'b0;
      end
      ST_DECAY: begin
        step  = rate_step(decay_rate, DR_SHIFT);
        bound = target;
      end
      ST_RELEASE: step = rate_step(release_rate, DR_SHIFT);
      default: ;
    endcase
  end

  env_step_sat #(.W(LEVEL_W)) u_step (
    .level   (level),
    .step    (step),
    .bound   (bound),
    .sub     (sub),
    .result  (step_result),
    .reached (reached)
  );

  // NOTE: all state here is registered with non-blocking assignments so every
  // right-hand side reads the value from before the edge.
  // NOTE: the asynchronous reset clears every register, including the trigger
  // latch, so no stale retrigger survives a mid-note reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      level        <= '0;
      sample_out   <= '0;
      gate_q       <= 1'b0;
      trig_pending <= 1'b0;
    end else begin
      gate_q     <= gate;
      sample_out <= product[SAMPLE_W+LEVEL_W-1:LEVEL_W];
      if (sample_tick) begin
        trig_pending <= 1'b0;
        // Retrigger keeps the current level (legato); stepping starts next tick.
        if (trig) begin
          state <= ST_ATTACK;
        end else if (!gate && (state == ST_ATTACK || state == ST_DECAY ||
                               state == ST_SUSTAIN)) begin
          state <= ST_RELEASE;
        end else begin
          case (state)
            ST_ATTACK: begin
              level <= step_result;
              if (reached) state <= ST_DECAY;
            end
            ST_DECAY: begin
              level <= step_result;
              if (reached) state <= ST_SUSTAIN;
            end
            ST_RELEASE: begin
              level <= step_result;
              if (reached) state <= ST_IDLE;
            end
            ST_SUSTAIN: level <= target;
            default:    level <= '0;
          endcase
        end
      end else if (gate && !gate_q) begin
        trig_pending <= 1'b1;
      end
    end
  end

endmodule
